qld_w6q4_pipe: RTL

//  Approximate logarithmic divider, the inverse of the QLM_w6q4 multiplier. Computes q ~= x / y with the same w6q4 log format:
//  one's-complement magnitude, LOD over bits [15:4], 4-bit characteristic and 5-bit fraction.

---
 rtl/qld_w6q4_pipe.sv | 111 +++++++++++
 1 files changed

// File: rtl/qld_w6q4_pipe.sv
// Approximate logarithmic divider (w6q4 log format), three-stage elastic pipeline with global stall.
// Optional divide-by-zero flag output dbz_o enabled by defining QLD_DBZ_FLAG_EN.
module qld_w6q4_pipe #(
  parameter int FRAC_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q_o
`ifdef QLD_DBZ_FLAG_EN
  ,
  output logic        dbz_o
`endif
);

  localparam int SHR = 17 - FRAC_W;

  // One's-complement magnitude with the four LSBs dropped; those never reach the log.
  function automatic logic [15:0] mag_hi(input logic [15:0] v);
    return (v ^ {16{v[15]}}) & 16'hFFF0;
  endfunction

  function automatic logic [9:0] log_enc(input logic [15:0] m);
    logic [3:0]  k;
    logic [15:0] n;
    k = 4'd4;
    for (int i = 4; i < 16; i++) begin
      if (m[i]) k = 4'(i);
    end
    n = m << (4'd15 - k);
    return {1'b0, k, n[14:10]};
  endfunction

  logic        adv;
  logic [15:0] x_mag, y_mag;

  logic        v1, v2;
  logic [9:0]  x_log1, y_log1;
  logic        x_zero1, y_zero1, sign1;

  logic [4:0]  kd2, f2;
  logic        x_zero2, y_zero2, sign2;

  logic [9:0]  d;
  logic [4:0]  s;
  logic [28:0] p;
  logic [31:0] q_mag, q_next;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign x_mag    = mag_hi(x_i);
  assign y_mag    = mag_hi(y_i);
  assign d        = x_log1 - y_log1;

  always_comb begin
    s      = kd2 + 5'd12;
    p      = 29'({1'b1, f2}) << s;
    q_mag  = 32'(p >> SHR);
    q_next = q_mag ^ {32{sign2}};
    if (y_zero2)      q_next = sign2 ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else if (x_zero2) q_next = 32'h0;
  end

  // NOTE: only the valid chain and the visible outputs take reset; payload registers
  // are qualified by their valid bit, so leaving them unreset saves reset fan-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      q_o       <= 32'h0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      q_o       <= q_next;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      x_log1  <= log_enc(x_mag);
      y_log1  <= log_enc(y_mag);
      x_zero1 <= (x_mag == 16'h0);
      y_zero1 <= (y_mag == 16'h0);
      sign1   <= x_i[15] ^ y_i[15];
      kd2     <= d[9:5];
      f2      <= d[4:0];
      x_zero2 <= x_zero1;
      y_zero2 <= y_zero1;
      sign2   <= sign1;
    end
  end

`ifdef QLD_DBZ_FLAG_EN
  logic dbz_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   dbz_r <= 1'b0;
    else if (adv) dbz_r <= y_zero2;
  end

  assign dbz_o = dbz_r & out_valid;
`endif

endmodule
